sf2_usram_sim: RTL and testbench
================================

Name: sf2_usram_sim

Overview:
- Parametrised simulation model of the SmartFusion2 micro-SRAM: one synchronous write port and two independent synchronous read ports (A, B).
- Each read port has an optional output pipeline register.
- Generalises the fixed 64x18 primitive in depth, width, read latency and read/write collision mode. Adds per-port valid tracking that the primitive does not provide.
- Sits alongside the SLE/CFG models in the SF2 cell simulation library; used by post-techmap simulation and as the target model for memory inference.

Parameters:
- WIDTH, 18, data width of every port, 1..36.
- DEPTH, 64, number of words, 2..1024; need not be a power of two.
- AWIDTH, 6, address width; must satisfy 2**AWIDTH >= DEPTH.
- A_PIPE, 0, 1 adds output register on port A (read latency 2 instead of 1).
- B_PIPE, 0, same as A_PIPE for port B.
- WRITE_MODE, 0, collision rule: 0 = read-old-data, 1 = write-through (new data).

Ports:
- CLK  in  1  single clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- W_EN  in  1  write enable.
- W_ADDR  in  AWIDTH  write address.
- W_DATA  in  WIDTH  write data.
- A_EN  in  1  port A read request; captures A_ADDR.
- A_ADDR  in  AWIDTH  port A read address.
- A_DOUT  out  WIDTH  port A read data.
- A_VALID  out  1  A_DOUT holds data of an accepted request.
- B_EN, B_ADDR, B_DOUT, B_VALID: identical to port A.

Behaviour:
- Storage: DEPTH x WIDTH array, all words zero at time 0. RST does not clear the array.
- Write: on a rising edge with W_EN=1 and W_ADDR<DEPTH, mem[W_ADDR] <= W_DATA. W_ADDR>=DEPTH is silently ignored.
- Read stage 1, per port: on a rising edge with EN=1, the port latches data = mem[ADDR] (value per collision rule) into its data register and sets valid1=1.
  - With EN=0, the data register holds its value and valid1 <= 0.
  - ADDR>=DEPTH returns all-zero data and still sets valid1.
- Read stage 2, only if PIPE=1: pipeline register loads stage-1 data and valid every cycle, with no enable.
- Latency: a request at edge N gives DOUT/VALID after edge N (PIPE=0) or after edge N+1 (PIPE=1).
  - Requests may be issued back-to-back every cycle at full throughput.
  - No backpressure.
- Collision, W_EN=1 with W_ADDR==ADDR on the same edge:
  - WRITE_MODE=0: read returns the pre-write word.
  - WRITE_MODE=1: read returns W_DATA.
  - The memory is written in both cases.
- Port A and port B reading the same address on the same edge: both return identical data.
- Reset: while RST=1 at an edge:
  - all data and pipeline registers <= 0, A_VALID=B_VALID=0;
  - requests on that edge are dropped;
  - writes on that edge are still performed;
  - requests in flight in the PIPE stage are discarded, not delivered after reset.
  - First valid output after reset deasserts follows the normal latency.
- DOUT holds its last value while VALID=0 (PIPE=0); with PIPE=1, DOUT follows stage 1, which holds.
- Parameter checks at elaboration: 2**AWIDTH<DEPTH, WIDTH outside 1..36, or WRITE_MODE outside 0..1 raises $error.
- No X propagation from the model itself. X on EN or W_EN corrupts state as in plain RTL; this is not checked.

Test Plan:
- Defaults. Reset, then write 18'h2A5A5 to addr 5, then A_EN with A_ADDR=5 on the next cycle -> one cycle later A_DOUT=18'h2A5A5, A_VALID=1. The following cycle with A_EN=0 -> A_VALID=0, A_DOUT holds.
- Collision. Preload addr 3=18'h00011. Same edge: W_EN with addr 3=18'h00022, and A_EN with A_ADDR=3.
  - WRITE_MODE=0 -> A_DOUT=18'h00011.
  - WRITE_MODE=1 -> A_DOUT=18'h00022.
  - A subsequent read of addr 3 gives 18'h00022 in both modes.
- A_PIPE=1, B_PIPE=0. Issue reads of addr 0..7 every cycle on both ports (data = addr*3) -> B_DOUT streams 0,3,..,21 starting one cycle after the first request; A_DOUT streams the same sequence one cycle later. VALID is high exactly 8 cycles on each port.
- DEPTH=40, AWIDTH=6. Write 18'h3FFFF to addr 45 -> no array change. Read addr 45 -> DOUT=0, VALID=1. Read addr 39 -> previously written value returned.
- Reset mid-stream, A_PIPE=1. Assert RST for one cycle while two reads are in flight -> A_VALID=0, A_DOUT=0 the cycle after reset; the in-flight results never appear. Array contents, including a write made during the reset edge, are intact on the next read.

Source files
------------

// File: rtl/sf2_usram_sim.sv
`default_nettype none
// ============================================================================
//  Module   : sf2_usram_sim
//  Purpose  : Parametrised SmartFusion2 micro-SRAM model. It has one write
//             port and two synchronous read ports, each with an optional
//             output register and valid tracking.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  sf2_usram_rd_port : read data / valid registers for one read port.
// ----------------------------------------------------------------------------
module sf2_usram_rd_port #(
    parameter int WIDTH = 18,
    parameter int PIPE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data1;
    logic             r_valid1;

    // Data holds when no request is issued; valid is a single-cycle marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data1  <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= i_en;
            if (i_en) begin
                r_data1 <= i_rdata;
            end
        end
    end

    if (PIPE == 1) begin : g_pipe
        logic [WIDTH-1:0] r_data2;
        logic             r_valid2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data2  <= '0;
                r_valid2 <= 1'b0;
            end else begin
                r_data2  <= r_data1;
                r_valid2 <= r_valid1;
            end
        end

        assign o_dout  = r_data2;
        assign o_valid = r_valid2;
    end else begin : g_direct
        assign o_dout  = r_data1;
        assign o_valid = r_valid1;
    end

endmodule

// ----------------------------------------------------------------------------
//  sf2_usram_sim : top level, storage array plus two read ports.
// ----------------------------------------------------------------------------
module sf2_usram_sim #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 64,
    parameter int AWIDTH     = 6,
    parameter int A_PIPE     = 0,
    parameter int B_PIPE     = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_EN,
    input  logic [AWIDTH-1:0] W_ADDR,
    input  logic [WIDTH-1:0]  W_DATA,
    input  logic              A_EN,
    input  logic [AWIDTH-1:0] A_ADDR,
    output logic [WIDTH-1:0]  A_DOUT,
    output logic              A_VALID,
    input  logic              B_EN,
    input  logic [AWIDTH-1:0] B_ADDR,
    output logic [WIDTH-1:0]  B_DOUT,
    output logic              B_VALID
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((1 << AWIDTH) < DEPTH) begin : g_bad_awidth
        $error("sf2_usram_sim: 2**AWIDTH (%0d) is smaller than DEPTH (%0d)", 1 << AWIDTH, DEPTH);
    end
    if (WIDTH < 1 || WIDTH > 36) begin : g_bad_width
        $error("sf2_usram_sim: WIDTH (%0d) outside 1..36", WIDTH);
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 1) begin : g_bad_wmode
        $error("sf2_usram_sim: WRITE_MODE (%0d) outside 0..1", WRITE_MODE);
    end

    // The array is not touched by RST; it starts out all-zero.
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic             w_wr_ok;
    logic [WIDTH-1:0] w_a_rdata;
    logic [WIDTH-1:0] w_b_rdata;

    assign w_wr_ok = W_EN && (32'(W_ADDR) < DEPTH);

    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[W_ADDR[c_IDX_W-1:0]] <= W_DATA;
        end
    end

    // Out-of-range reads give zero. In write-through mode a same-edge write
    // to the same address is forwarded; otherwise the pre-write word is read.
    function automatic logic [WIDTH-1:0] f_read(input logic [AWIDTH-1:0] addr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (32'(addr) < DEPTH) begin
            if (WRITE_MODE == 1 && W_EN && (W_ADDR == addr)) begin
                v = W_DATA;
            end else begin
                v = r_mem[addr[c_IDX_W-1:0]];
            end
        end
        return v;
    endfunction

    always_comb begin
        w_a_rdata = f_read(A_ADDR);
        w_b_rdata = f_read(B_ADDR);
    end

    sf2_usram_rd_port #(
        .WIDTH (WIDTH),
        .PIPE  (A_PIPE)
    ) u_port_a (
        .clk     (CLK),
        .rst     (RST),
        .i_en    (A_EN),
        .i_rdata (w_a_rdata),
        .o_dout  (A_DOUT),
        .o_valid (A_VALID)
    );

    sf2_usram_rd_port #(
        .WIDTH (WIDTH),
        .PIPE  (B_PIPE)
    ) u_port_b (
        .clk     (CLK),
        .rst     (RST),
        .i_en    (B_EN),
        .i_rdata (w_b_rdata),
        .o_dout  (B_DOUT),
        .o_valid (B_VALID)
    );

endmodule

`default_nettype wire

// File: tb/tb_sf2_usram_sim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sf2_usram_sim
//  Purpose  : Four configurations of sf2_usram_sim driven by shared stimulus
//             and checked against a behavioural memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sf2_usram_sim;

    localparam int c_NCFG = 4;
    // cfg0: defaults | cfg1: write-through | cfg2: A_PIPE=1 | cfg3: DEPTH=40, both piped, write-through
    localparam int c_DEP  [c_NCFG] = '{64, 64, 64, 40};
    localparam int c_WM   [c_NCFG] = '{0, 1, 0, 1};
    localparam int c_APIP [c_NCFG] = '{0, 0, 1, 1};
    localparam int c_BPIP [c_NCFG] = '{0, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [5:0]  w_addr;
    logic [17:0] w_data;
    logic        a_en;
    logic [5:0]  a_addr;
    logic        b_en;
    logic [5:0]  b_addr;

    logic [17:0] d0_ad, d0_bd, d1_ad, d1_bd, d2_ad, d2_bd, d3_ad, d3_bd;
    logic        d0_av, d0_bv, d1_av, d1_bv, d2_av, d2_bv, d3_av, d3_bv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sf2_usram_sim #(.WIDTH(18), .DEPTH(64), .AWIDTH(6), .A_PIPE(0), .B_PIPE(0), .WRITE_MODE(0)) u_d0 (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
        .A_EN(a_en), .A_ADDR(a_addr), .A_DOUT(d0_ad), .A_VALID(d0_av),
        .B_EN(b_en), .B_ADDR(b_addr), .B_DOUT(d0_bd), .B_VALID(d0_bv));
    sf2_usram_sim #(.WIDTH(18), .DEPTH(64), .AWIDTH(6), .A_PIPE(0), .B_PIPE(0), .WRITE_MODE(1)) u_d1 (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
        .A_EN(a_en), .A_ADDR(a_addr), .A_DOUT(d1_ad), .A_VALID(d1_av),
        .B_EN(b_en), .B_ADDR(b_addr), .B_DOUT(d1_bd), .B_VALID(d1_bv));
    sf2_usram_sim #(.WIDTH(18), .DEPTH(64), .AWIDTH(6), .A_PIPE(1), .B_PIPE(0), .WRITE_MODE(0)) u_d2 (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
        .A_EN(a_en), .A_ADDR(a_addr), .A_DOUT(d2_ad), .A_VALID(d2_av),
        .B_EN(b_en), .B_ADDR(b_addr), .B_DOUT(d2_bd), .B_VALID(d2_bv));
    sf2_usram_sim #(.WIDTH(18), .DEPTH(40), .AWIDTH(6), .A_PIPE(1), .B_PIPE(1), .WRITE_MODE(1)) u_d3 (
        .CLK(clk), .RST(rst), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
        .A_EN(a_en), .A_ADDR(a_addr), .A_DOUT(d3_ad), .A_VALID(d3_av),
        .B_EN(b_en), .B_ADDR(b_addr), .B_DOUT(d3_bd), .B_VALID(d3_bv));

    // ---------------- behavioural model ----------------
    logic [17:0] m_mem   [c_NCFG][64];
    logic [17:0] m_s1d   [c_NCFG][2];
    logic        m_s1v   [c_NCFG][2];
    logic [17:0] m_expd  [c_NCFG][2];
    logic        m_expv  [c_NCFG][2];
    bit          started = 1'b0;

    initial begin
        for (int c = 0; c < c_NCFG; c++)
            for (int i = 0; i < 64; i++)
                m_mem[c][i] = '0;
    end

    function automatic logic [17:0] model_read(input int c, input logic [5:0] addr);
        if (int'(addr) >= c_DEP[c]) return '0;
        if (c_WM[c] == 1 && w_en && w_addr == addr) return w_data;
        return m_mem[c][addr];
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < c_NCFG; c++) begin
            for (int p = 0; p < 2; p++) begin
                logic        en;
                logic [5:0]  ad;
                logic [17:0] old_d;
                logic        old_v;
                en    = (p == 0) ? a_en : b_en;
                ad    = (p == 0) ? a_addr : b_addr;
                old_d = m_s1d[c][p];
                old_v = m_s1v[c][p];
                if (rst) begin
                    m_s1d[c][p] = '0;
                    m_s1v[c][p] = 1'b0;
                end else if (en) begin
                    m_s1d[c][p] = model_read(c, ad);
                    m_s1v[c][p] = 1'b1;
                end else begin
                    m_s1v[c][p] = 1'b0;
                end
                if (((p == 0) ? c_APIP[c] : c_BPIP[c]) == 1) begin
                    m_expd[c][p] = rst ? 18'h0 : old_d;
                    m_expv[c][p] = rst ? 1'b0 : old_v;
                end else begin
                    m_expd[c][p] = m_s1d[c][p];
                    m_expv[c][p] = m_s1v[c][p];
                end
            end
            if (w_en && int'(w_addr) < c_DEP[c]) m_mem[c][w_addr] = w_data;
        end
        if (rst) started = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            logic [17:0] ad [c_NCFG][2];
            logic        av [c_NCFG][2];
            ad[0][0] = d0_ad; ad[0][1] = d0_bd; av[0][0] = d0_av; av[0][1] = d0_bv;
            ad[1][0] = d1_ad; ad[1][1] = d1_bd; av[1][0] = d1_av; av[1][1] = d1_bv;
            ad[2][0] = d2_ad; ad[2][1] = d2_bd; av[2][0] = d2_av; av[2][1] = d2_bv;
            ad[3][0] = d3_ad; ad[3][1] = d3_bd; av[3][0] = d3_av; av[3][1] = d3_bv;
            for (int c = 0; c < c_NCFG; c++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (ad[c][p] !== m_expd[c][p] || av[c][p] !== m_expv[c][p]) begin
                        errors++;
                        $display("FAIL model cfg%0d port%s t=%0t: got valid=%b dout=%h, expected valid=%b dout=%h",
                                 c, (p == 0) ? "A" : "B", $time, av[c][p], ad[c][p], m_expv[c][p], m_expd[c][p]);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input logic [5:0] wa, input logic [17:0] wd,
                       input logic ae, input logic [5:0] aa, input logic be, input logic [5:0] ba);
        rst = r; w_en = we; w_addr = wa; w_data = wd;
        a_en = ae; a_addr = aa; b_en = be; b_addr = ba;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        cyc(1'b1, 1'b0, 6'd0, 18'h0, 1'b0, 6'd0, 1'b0, 6'd0);
        cyc(1'b1, 1'b0, 6'd0, 18'h0, 1'b0, 6'd0, 1'b0, 6'd0);
        check("reset_d0_a_valid", 18'(d0_av), 18'h0);
        check("reset_d0_a_dout", d0_ad, 18'h0);

        // Basic write then read on default config
        cyc(1'b0, 1'b1, 6'd5, 18'h2A5A5, 1'b0, 6'd0, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd5, 1'b1, 6'd5);
        check("basic_a_dout", d0_ad, 18'h2A5A5);
        check("basic_a_valid", 18'(d0_av), 18'h1);
        check("basic_b_dout", d0_bd, 18'h2A5A5);
        idle();
        check("hold_a_valid", 18'(d0_av), 18'h0);
        check("hold_a_dout", d0_ad, 18'h2A5A5);

        // Read/write collision
        cyc(1'b0, 1'b1, 6'd3, 18'h00011, 1'b0, 6'd0, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 6'd3, 18'h00022, 1'b1, 6'd3, 1'b0, 6'd0);
        check("collide_old_data", d0_ad, 18'h00011);
        check("collide_write_thru", d1_ad, 18'h00022);
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd3, 1'b0, 6'd0);
        check("after_collide_wm0", d0_ad, 18'h00022);
        check("after_collide_wm1", d1_ad, 18'h00022);

        // Streaming reads, A piped and B direct on cfg2
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 6'(i), 18'(i * 3), 1'b0, 6'd0, 1'b0, 6'd0);
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'(k), 1'b1, 6'(k));
            else idle();
            if (d2_av) cnt_a++;
            if (d2_bv) cnt_b++;
            if (k < 8) check($sformatf("stream_b_%0d", k), d2_bd, 18'(k * 3));
            if (k >= 1 && k < 9) check($sformatf("stream_a_%0d", k - 1), d2_ad, 18'((k - 1) * 3));
        end
        check("stream_a_valid_count", 18'(cnt_a), 18'd8);
        check("stream_b_valid_count", 18'(cnt_b), 18'd8);

        // Out-of-range addressing on the DEPTH=40 config
        cyc(1'b0, 1'b1, 6'd39, 18'h12345, 1'b0, 6'd0, 1'b0, 6'd0);
        cyc(1'b0, 1'b1, 6'd45, 18'h3FFFF, 1'b0, 6'd0, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd45, 1'b1, 6'd39);
        check("depth64_addr45", d0_ad, 18'h3FFFF);
        idle();
        check("oor_a_dout", d3_ad, 18'h0);
        check("oor_a_valid", 18'(d3_av), 18'h1);
        check("oor_b_dout_39", d3_bd, 18'h12345);
        check("oor_b_valid", 18'(d3_bv), 18'h1);

        // Reset with reads in flight on the piped port; write during reset
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd1, 1'b0, 6'd0);
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd2, 1'b0, 6'd0);
        check("pre_reset_pipe_a", d2_ad, 18'h3);
        cyc(1'b1, 1'b1, 6'd10, 18'h0ABCD, 1'b1, 6'd3, 1'b0, 6'd0);
        check("rst_pipe_a_valid", 18'(d2_av), 18'h0);
        check("rst_pipe_a_dout", d2_ad, 18'h0);
        check("rst_direct_a_dout", d0_ad, 18'h0);
        idle();
        check("post_rst_pipe_a_valid", 18'(d2_av), 18'h0);
        check("post_rst_pipe_a_dout", d2_ad, 18'h0);
        cyc(1'b0, 1'b0, 6'd0, 18'h0, 1'b1, 6'd10, 1'b0, 6'd0);
        check("rst_write_direct", d0_ad, 18'h0ABCD);
        idle();
        check("rst_write_pipe", d2_ad, 18'h0ABCD);
        check("rst_write_pipe_valid", 18'(d2_av), 18'h1);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
